// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one data-bus transaction per memory op, lane-aligned
// stores and sign/zero-extended loads. Define MEM_MISALIGN_TRAP_EN to trap misaligned ops.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [3:0]        in_memop,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flush,
    output logic              busy,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_exc
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e            state_q, state_d;
    logic [3:0]        memop_q, memop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [7:0]        strobe_q, strobe_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              kill_q, kill_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_rdata_q, out_rdata_d;

    logic [2:0]        in_off;
    logic              in_is_mem, in_is_store;
    logic [2:0]        in_size;
    logic [7:0]        in_strobe;
    logic [DATA_W-1:0] rd_shifted, load_ext;

    assign in_off      = in_addr[2:0];
    assign in_is_mem   = (in_memop >= 4'd1) && (in_memop <= 4'd11);
    assign in_is_store = (in_memop >= 4'd8) && (in_memop <= 4'd11);

    always_comb begin
        in_size = 3'd0;
        unique case (in_memop)
            4'd2, 4'd6, 4'd9:  in_size = 3'd1;
            4'd3, 4'd7, 4'd10: in_size = 3'd2;
            4'd4, 4'd11:       in_size = 3'd3;
            default:           in_size = 3'd0;
        endcase
    end

    // Bytes pushed past lane 7 fall off the 8-bit shift
    always_comb begin
        in_strobe = 8'h00;
        if (in_is_store) begin
            unique case (in_size)
                3'd0:    in_strobe = 8'h01 << in_off;
                3'd1:    in_strobe = 8'h03 << in_off;
                3'd2:    in_strobe = 8'h0F << in_off;
                default: in_strobe = 8'hFF;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic in_misalign;
    assign in_misalign = ((in_size == 3'd1) && in_off[0]) ||
                         ((in_size == 3'd2) && (in_off[1:0] != 2'd0)) ||
                         ((in_size == 3'd3) && (in_off != 3'd0));
    logic out_exc_q, out_exc_d;
`endif

    assign rd_shifted = dresp_data >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_ext = '0;
        unique case (memop_q)
            4'd1:    load_ext = {{56{rd_shifted[7]}}, rd_shifted[7:0]};
            4'd2:    load_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            4'd3:    load_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            4'd4:    load_ext = rd_shifted;
            4'd5:    load_ext = {56'd0, rd_shifted[7:0]};
            4'd6:    load_ext = {48'd0, rd_shifted[15:0]};
            4'd7:    load_ext = {32'd0, rd_shifted[31:0]};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        memop_d     = memop_q;
        addr_d      = addr_q;
        size_d      = size_q;
        strobe_d    = strobe_q;
        data_d      = data_q;
        kill_d      = kill_q;
        out_valid_d = 1'b0;
        out_rdata_d = out_rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
        out_exc_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    if (!in_is_mem) begin
                        out_valid_d = 1'b1;
                        out_rdata_d = '0;
`ifdef MEM_MISALIGN_TRAP_EN
                    end else if (in_misalign) begin
                        out_valid_d = 1'b1;
                        out_rdata_d = '0;
                        out_exc_d   = 1'b1;
`endif
                    end else begin
                        state_d  = StReq;
                        memop_d  = in_memop;
                        addr_d   = in_addr;
                        size_d   = in_size;
                        strobe_d = in_strobe;
                        data_d   = in_wdata << {in_off, 3'b000};
                        kill_d   = 1'b0;
                    end
                end
            end
            StReq: begin
                // The bus op always runs to completion; a flush only hides the result
                kill_d = kill_q | flush;
                if (dresp_data_ok) begin
                    state_d  = StIdle;
                    kill_d   = 1'b0;
                    strobe_d = 8'h00;
                    if (!(kill_q || flush)) begin
                        out_valid_d = 1'b1;
                        out_rdata_d = load_ext;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            memop_q     <= 4'd0;
            addr_q      <= '0;
            size_q      <= 3'd0;
            strobe_q    <= 8'h00;
            data_q      <= '0;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            out_exc_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            memop_q     <= memop_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            strobe_q    <= strobe_d;
            data_q      <= data_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_rdata_q <= out_rdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
            out_exc_q   <= out_exc_d;
`endif
        end
    end

    assign busy        = (state_q == StReq);
    assign dreq_valid  = (state_q == StReq);
    assign dreq_addr   = addr_q;
    assign dreq_size   = size_q;
    assign dreq_strobe = strobe_q;
    assign dreq_data   = data_q;
    assign out_valid   = out_valid_q;
    assign out_rdata   = out_rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign out_exc     = out_exc_q;
`else
    assign out_exc     = 1'b0;
`endif

endmodule
